mux_5bit: RTL and testbench
===========================

MUX_5BIT -- requirements
Module: mux_5bit

Interface
REQ-001 Parameter: WIDTH, default 5, data width of both inputs and all data outputs.
REQ-002 Parameter: RESET_VAL, default 0 (WIDTH bits), value loaded into registered output on reset.
REQ-003 Port: clk  input  1  single clock; all registers update on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high; one clock, no other clock domain.
REQ-005 Port: input0  input  WIDTH  data routed when select=0.
REQ-006 Port: input1  input  WIDTH  data routed when select=1.
REQ-007 Port: select  input  1  route control; 0 -> input0, 1 -> input1.
REQ-008 Port: mux_output  output  WIDTH  combinational selected data.
REQ-009 Port: mux_output_q  output  WIDTH  registered copy of mux_output.
REQ-010 Port: sel_q  output  1  registered copy of select.

Function
REQ-011 mux_output SHALL equal input0 when select=0 and input1 when select=1, purely combinational, zero clock latency, full WIDTH bits, no truncation or extension.
REQ-012 mux_output SHALL respond to any change on input0, input1 or select within the same delta/cycle, independent of clk and rst.
REQ-013 A change on the non-selected input SHALL NOT affect mux_output.
REQ-014 mux_output SHALL be unaffected by rst (reset only acts on registers).
REQ-015 On each rising clk edge with rst=0, mux_output_q SHALL load the current mux_output value (latency exactly 1 cycle).
REQ-016 On each rising clk edge with rst=0, sel_q SHALL load the current select value.
REQ-017 Simultaneous change of select and the newly selected input SHALL produce the new input's value on mux_output immediately and on mux_output_q at the next edge.
REQ-018 Narrow stimulus (e.g. 1'b1 driven into a WIDTH port) SHALL be zero-extended by the driving context; the block performs no sign extension.
REQ-019 Design SHALL contain no latches and no combinational loops; all registered state limited to mux_output_q and sel_q.

Reset
REQ-020 On a rising clk edge with rst=1, mux_output_q SHALL become RESET_VAL (0) and sel_q SHALL become 0, regardless of other inputs.
REQ-021 rst asserted mid-operation SHALL take effect at the next rising edge only; registers hold their prior value between rst assertion and that edge.
REQ-022 First rising edge after rst deasserts SHALL capture normal mux_output.
REQ-023 Before first reset edge registered outputs are undefined; benches SHALL apply rst for at least one edge.

Verification
REQ-024 select=0, input0=0, input1=0 -> mux_output=00; after one edge mux_output_q=00.
REQ-025 select=0, input0=01, input1=00 -> mux_output=01 immediately; mux_output_q=01 after next edge.
REQ-026 select=1, input0=01, input1=00 -> mux_output=00; sel_q=1 after next edge.
REQ-027 select=1, input1=01 -> mux_output=01; then change input0 to 1F -> mux_output stays 01.
REQ-028 mux_output_q=01, assert rst for one edge with select=1, input1=1F -> mux_output_q=00, sel_q=0, mux_output=1F throughout.
REQ-029 Random WIDTH=5 sweep of all 2x32x32 input combinations -> mux_output matches select ? input1 : input0 every time, mux_output_q matches it one cycle later.

Source files
------------

// File: rtl/mux_5bit.sv
// Two-input WIDTH-bit multiplexer with a combinational output and a
// registered copy of both the selected data and the select line.
module mux_5bit #(
  parameter int unsigned      WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  input  logic             select,
  output logic [WIDTH-1:0] mux_output,
  output logic [WIDTH-1:0] mux_output_q,
  output logic             sel_q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             select_d;
  logic             select_q;

  // Selection stays outside the register path so the combinational output
  // never sees the reset.
  always_comb begin
    data_d   = input0;
    select_d = select;
    if (select) begin
      data_d = input1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= RESET_VAL;
      select_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      select_q <= select_d;
    end
  end

  assign mux_output   = data_d;
  assign mux_output_q = data_q;
  assign sel_q        = select_q;

endmodule

// File: tb/tb_mux_5bit.sv
// Directed checks of the mux and its output registers, followed by an
// exhaustive sweep of every select/input0/input1 combination.
module tb_mux_5bit;

  localparam int unsigned WIDTH = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] input0;
  logic [WIDTH-1:0] input1;
  logic             select;
  logic [WIDTH-1:0] mux_output;
  logic [WIDTH-1:0] mux_output_q;
  logic             sel_q;

  int checks_cnt;
  int errors_cnt;

  mux_5bit #(
    .WIDTH    (WIDTH),
    .RESET_VAL(5'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input0      (input0),
    .input1      (input1),
    .select      (select),
    .mux_output  (mux_output),
    .mux_output_q(mux_output_q),
    .sel_q       (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the clock edge and let them settle.
  task automatic drive(input logic sel, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    select = sel;
    input0 = a;
    input1 = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst    = 1'b1;
    select = 1'b1;
    input0 = 5'h0A;
    input1 = 5'h15;

    // Reset edge with non-zero inputs: registers must clear anyway.
    tick();
    check("reset_data_q", mux_output_q, 5'h00);
    check("reset_sel_q", {4'b0, sel_q}, 5'h00);
    check("reset_comb", mux_output, 5'h15);
    $display("txn reset: mux_output_q=%h sel_q=%b", mux_output_q, sel_q);
    rst = 1'b0;

    // All zero inputs.
    drive(1'b0, 5'h00, 5'h00);
    check("zero_comb", mux_output, 5'h00);
    tick();
    check("zero_q", mux_output_q, 5'h00);
    $display("txn zero: mux_output=%h mux_output_q=%h", mux_output, mux_output_q);

    // input0 selected, immediate on comb output, one cycle on register.
    drive(1'b0, 5'h01, 5'h00);
    check("sel0_comb", mux_output, 5'h01);
    check("sel0_q_before_edge", mux_output_q, 5'h00);
    tick();
    check("sel0_q", mux_output_q, 5'h01);
    check("sel0_sel_q", {4'b0, sel_q}, 5'h00);
    $display("txn sel0: mux_output=%h mux_output_q=%h", mux_output, mux_output_q);

    // Switch to input1 which is zero.
    drive(1'b1, 5'h01, 5'h00);
    check("sel1_comb", mux_output, 5'h00);
    tick();
    check("sel1_sel_q", {4'b0, sel_q}, 5'h01);
    check("sel1_q", mux_output_q, 5'h00);
    $display("txn sel1: mux_output=%h sel_q=%b", mux_output, sel_q);

    // Non-selected input change must not disturb the output.
    drive(1'b1, 5'h01, 5'h01);
    check("unsel_before", mux_output, 5'h01);
    drive(1'b1, 5'h1F, 5'h01);
    check("unsel_after", mux_output, 5'h01);
    tick();
    check("unsel_q", mux_output_q, 5'h01);
    $display("txn unsel: mux_output=%h mux_output_q=%h", mux_output, mux_output_q);

    // Mid-cycle reset: registers hold until the edge, comb output unaffected.
    drive(1'b1, 5'h00, 5'h1F);
    rst = 1'b1;
    #1;
    check("rst_hold_q", mux_output_q, 5'h01);
    check("rst_hold_sel_q", {4'b0, sel_q}, 5'h01);
    check("rst_comb_pre", mux_output, 5'h1F);
    tick();
    check("rst_q", mux_output_q, 5'h00);
    check("rst_sel_q", {4'b0, sel_q}, 5'h00);
    check("rst_comb_post", mux_output, 5'h1F);
    $display("txn midreset: mux_output=%h mux_output_q=%h sel_q=%b",
             mux_output, mux_output_q, sel_q);

    // First edge after reset release captures normal data.
    rst = 1'b0;
    tick();
    check("post_rst_q", mux_output_q, 5'h1F);
    check("post_rst_sel_q", {4'b0, sel_q}, 5'h01);
    $display("txn release: mux_output_q=%h sel_q=%b", mux_output_q, sel_q);

    // Simultaneous select and newly-selected input change.
    drive(1'b0, 5'h0C, 5'h1F);
    check("simul_comb", mux_output, 5'h0C);
    tick();
    check("simul_q", mux_output_q, 5'h0C);
    check("simul_sel_q", {4'b0, sel_q}, 5'h00);
    $display("txn simul: mux_output=%h mux_output_q=%h", mux_output, mux_output_q);

    // Narrow literal is zero-extended by the driver.
    drive(1'b1, 5'h1E, 5'(1'b1));
    check("narrow_comb", mux_output, 5'h01);
    tick();
    check("narrow_q", mux_output_q, 5'h01);
    $display("txn narrow: mux_output=%h", mux_output);

    // Exhaustive sweep of every combination.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 32; b++) begin
          logic [WIDTH-1:0] exp_v;
          exp_v = (s != 0) ? 5'(b) : 5'(a);
          drive(s[0], 5'(a), 5'(b));
          check("sweep_comb", mux_output, exp_v);
          tick();
          check("sweep_q", mux_output_q, exp_v);
          check("sweep_sel_q", {4'b0, sel_q}, {4'b0, s[0]});
        end
      end
    end
    $display("txn sweep: 2048 combinations applied");

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
